direct_cache_ctrl: RTL and testbench



---
 rtl/direct_cache_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_direct_cache_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/direct_cache_ctrl.sv
// direct_cache_ctrl
//   Direct-mapped, write-through, one-word-per-line cache controller between a
//   CPU load/store port and a slower backing memory. Loads that miss fetch the
//   word and allocate the line. Stores always write through to memory: a store
//   hit also updates the line, and a store miss leaves the cache untouched.
//   Provides a whole-cache flush and saturating hit/miss counters.
//
// Ports
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   req_*                 CPU request channel (valid/ready, we, addr, wdata)
//   resp_*                one-cycle completion pulse with load data and hit flag
//   flush                 invalidate all lines (only honoured in IDLE)
//   mem_req_*, mem_we,
//   mem_addr, mem_wdata   backing-memory request channel (valid/ready)
//   mem_resp_valid,
//   mem_rdata             backing-memory read data return
//   hit_cnt, miss_cnt     saturating access counters
module direct_cache_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int C          = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_hit,
  input  logic                  flush,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [CNT_WIDTH-1:0]  hit_cnt,
  output logic [CNT_WIDTH-1:0]  miss_cnt
);

  localparam int LINES = 2 ** C;
  localparam int TAG_W = ADDR_WIDTH - C - 2;
  localparam int WA_W  = ADDR_WIDTH - 2;

  typedef enum logic [2:0] {IDLE, RESP, MEM_RD, MEM_WAIT, MEM_WR} state_t;

  state_t                  state_q, state_d;
  logic [LINES-1:0]        valid_q, valid_d;
  logic [TAG_W-1:0]        tag_mem_q  [LINES];
  logic [DATA_WIDTH-1:0]   data_mem_q [LINES];
  // Latched word address of the accepted request: {tag, index}.
  logic [WA_W-1:0]         waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    hit_q, hit_d;
  logic [CNT_WIDTH-1:0]    hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]    miss_cnt_q, miss_cnt_d;

  logic                    line_we;
  logic [C-1:0]            line_idx;
  logic [TAG_W-1:0]        line_tag;
  logic [DATA_WIDTH-1:0]   line_data;

  logic [C-1:0]            req_idx;
  logic [TAG_W-1:0]        req_tag;
  logic                    lookup_hit;
  logic                    accept;
  logic                    unused_addr_lsb;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  assign req_idx         = req_addr[C+1:2];
  assign req_tag         = req_addr[ADDR_WIDTH-1:C+2];
  assign lookup_hit      = valid_q[req_idx] && (tag_mem_q[req_idx] == req_tag);
  assign unused_addr_lsb = ^req_addr[1:0];

  assign req_ready     = (state_q == IDLE) && !flush;
  assign accept        = req_valid && req_ready;
  assign resp_valid    = (state_q == RESP);
  assign resp_hit      = hit_q;
  assign resp_rdata    = rdata_q;
  assign mem_req_valid = (state_q == MEM_RD) || (state_q == MEM_WR);
  assign mem_we        = (state_q == MEM_WR);
  // Memory-side outputs are zero whenever no request is outstanding.
  assign mem_addr      = mem_req_valid ? {waddr_q, 2'b00} : '0;
  assign mem_wdata     = mem_we ? wdata_q : '0;
  assign hit_cnt       = hit_cnt_q;
  assign miss_cnt      = miss_cnt_q;

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    hit_d      = hit_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    line_we    = 1'b0;
    line_idx   = req_idx;
    line_tag   = req_tag;
    line_data  = req_wdata;

    unique case (state_q)
      IDLE: begin
        if (flush) begin
          valid_d = '0;
        end else if (accept) begin
          waddr_d = req_addr[ADDR_WIDTH-1:2];
          wdata_d = req_wdata;
          hit_d   = lookup_hit;
          if (lookup_hit) hit_cnt_d  = sat_inc(hit_cnt_q);
          else            miss_cnt_d = sat_inc(miss_cnt_q);
          if (req_we) begin
            // Write-update on hit; a store miss does not allocate.
            line_we = lookup_hit;
            state_d = MEM_WR;
          end else if (lookup_hit) begin
            rdata_d = data_mem_q[req_idx];
            state_d = RESP;
          end else begin
            state_d = MEM_RD;
          end
        end
      end
      MEM_RD: begin
        if (mem_req_ready) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (mem_resp_valid) begin
          line_we           = 1'b1;
          line_idx          = waddr_q[C-1:0];
          line_tag          = waddr_q[WA_W-1:C];
          line_data         = mem_rdata;
          valid_d[line_idx] = 1'b1;
          rdata_d           = mem_rdata;
          state_d           = RESP;
        end
      end
      MEM_WR: begin
        if (mem_req_ready) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      hit_q      <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      hit_q      <= hit_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Tag and data arrays carry no reset; valid_q alone qualifies their contents.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_mem_q[line_idx]  <= line_tag;
      data_mem_q[line_idx] <= line_data;
    end
  end

endmodule

// File: tb/tb_direct_cache_ctrl.sv
module tb_direct_cache_ctrl;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_hit;
  logic        flush;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  direct_cache_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_hit       (resp_hit),
    .flush          (flush),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata),
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Backing memory: read data returns RD_GAP+1 cycles after the handshake cycle.
  localparam int RD_GAP = 2;
  logic [31:0] mem_model [logic [31:0]];
  int          n_rd = 0;
  int          n_wr = 0;
  logic [31:0] last_rd_addr = '0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;
  logic        stale_pulse  = 1'b0;

  initial begin
    logic        rd_pending;
    int          rd_cnt;
    logic [31:0] rd_data;
    rd_pending     = 1'b0;
    rd_cnt         = 0;
    rd_data        = '0;
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
    forever begin
      @(negedge clk);
      mem_resp_valid = stale_pulse;
      if (rd_pending) begin
        if (rd_cnt == 0) begin
          mem_resp_valid = 1'b1;
          mem_rdata      = rd_data;
          rd_pending     = 1'b0;
        end else begin
          rd_cnt--;
        end
      end
      if (reset_n && mem_req_valid && mem_req_ready) begin
        if (mem_we) begin
          n_wr++;
          last_wr_addr        = mem_addr;
          last_wr_data        = mem_wdata;
          mem_model[mem_addr] = mem_wdata;
        end else begin
          n_rd++;
          last_rd_addr = mem_addr;
          rd_data      = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
          rd_cnt       = RD_GAP;
          rd_pending   = 1'b1;
        end
      end
    end
  end

  // Issues one CPU request and returns the response; lat counts clock edges
  // from the accepting edge up to the cycle in which resp_valid is seen.
  task automatic cpu_req(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic hit, output int lat);
    int t;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    #1;
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!req_ready) check_eq({tag, "_accept_timeout"}, 64'd0, 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) check_eq({tag, "_resp_timeout"}, 64'd0, 64'd1);
    rdata = resp_rdata;
    hit   = resp_hit;
    @(negedge clk);
    check_eq({tag, "_resp_one_cycle"}, {63'd0, resp_valid}, 64'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        h;
    int          lat;
    reset_n       = 1'b0;
    req_valid     = 1'b0;
    req_we        = 1'b0;
    req_addr      = '0;
    req_wdata     = '0;
    flush         = 1'b0;
    mem_req_ready = 1'b1;
    mem_model[32'h10] = 32'hDEAD_BEEF;
    mem_model[32'h30] = 32'hC0DE_0030;

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rst_req_ready", {63'd0, req_ready}, 64'd1);
    check_eq("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check_eq("rst_resp_hit", {63'd0, resp_hit}, 64'd0);
    check_eq("rst_resp_rdata", {32'd0, resp_rdata}, 64'd0);
    check_eq("rst_mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
    check_eq("rst_mem_we", {63'd0, mem_we}, 64'd0);
    check_eq("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
    check_eq("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
    check_eq("rst_hit_cnt", {48'd0, hit_cnt}, 64'd0);
    check_eq("rst_miss_cnt", {48'd0, miss_cnt}, 64'd0);

    // Cold load miss
    cpu_req("ld10_miss", 1'b0, 32'h10, 32'h0, rd, h, lat);
    check_eq("ld10_miss_data", {32'd0, rd}, 64'hDEAD_BEEF);
    check_eq("ld10_miss_hit", {63'd0, h}, 64'd0);
    check_eq("ld10_miss_lat", lat, 64'd5);
    check_eq("ld10_miss_nrd", n_rd, 64'd1);
    check_eq("ld10_miss_addr", {32'd0, last_rd_addr}, 64'h10);
    check_eq("ld10_miss_cnt", {48'd0, miss_cnt}, 64'd1);

    // Load hit
    cpu_req("ld10_hit", 1'b0, 32'h10, 32'h0, rd, h, lat);
    check_eq("ld10_hit_data", {32'd0, rd}, 64'hDEAD_BEEF);
    check_eq("ld10_hit_hit", {63'd0, h}, 64'd1);
    check_eq("ld10_hit_lat", lat, 64'd1);
    check_eq("ld10_hit_nrd", n_rd, 64'd1);
    check_eq("ld10_hit_cnt", {48'd0, hit_cnt}, 64'd1);

    // Store hit, write-update, then load hit
    cpu_req("st10", 1'b1, 32'h10, 32'h1234_5678, rd, h, lat);
    check_eq("st10_hit", {63'd0, h}, 64'd1);
    check_eq("st10_lat", lat, 64'd2);
    check_eq("st10_nwr", n_wr, 64'd1);
    check_eq("st10_wr_addr", {32'd0, last_wr_addr}, 64'h10);
    check_eq("st10_wr_data", {32'd0, last_wr_data}, 64'h1234_5678);
    check_eq("st10_hit_cnt", {48'd0, hit_cnt}, 64'd2);
    cpu_req("ld10_after_st", 1'b0, 32'h10, 32'h0, rd, h, lat);
    check_eq("ld10_after_st_data", {32'd0, rd}, 64'h1234_5678);
    check_eq("ld10_after_st_hit", {63'd0, h}, 64'd1);
    check_eq("ld10_after_st_hcnt", {48'd0, hit_cnt}, 64'd3);

    // Store miss does not allocate
    cpu_req("st44", 1'b1, 32'h44, 32'hAAAA_AAAA, rd, h, lat);
    check_eq("st44_hit", {63'd0, h}, 64'd0);
    check_eq("st44_wr_addr", {32'd0, last_wr_addr}, 64'h44);
    check_eq("st44_mcnt", {48'd0, miss_cnt}, 64'd2);
    cpu_req("ld44", 1'b0, 32'h44, 32'h0, rd, h, lat);
    check_eq("ld44_hit", {63'd0, h}, 64'd0);
    check_eq("ld44_data", {32'd0, rd}, 64'hAAAA_AAAA);
    check_eq("ld44_mcnt", {48'd0, miss_cnt}, 64'd3);

    // Conflict misses on index 4
    cpu_req("cf30a", 1'b0, 32'h30, 32'h0, rd, h, lat);
    check_eq("cf30a_hit", {63'd0, h}, 64'd0);
    check_eq("cf30a_data", {32'd0, rd}, 64'hC0DE_0030);
    cpu_req("cf10", 1'b0, 32'h10, 32'h0, rd, h, lat);
    check_eq("cf10_hit", {63'd0, h}, 64'd0);
    check_eq("cf10_data", {32'd0, rd}, 64'h1234_5678);
    cpu_req("cf30b", 1'b0, 32'h30, 32'h0, rd, h, lat);
    check_eq("cf30b_hit", {63'd0, h}, 64'd0);
    check_eq("cf_mcnt", {48'd0, miss_cnt}, 64'd6);

    // Cache 0x10, then flush with a pending request
    cpu_req("pf10a", 1'b0, 32'h10, 32'h0, rd, h, lat);
    cpu_req("pf10b", 1'b0, 32'h10, 32'h0, rd, h, lat);
    check_eq("pf10b_hit", {63'd0, h}, 64'd1);
    @(negedge clk);
    flush     = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h10;
    #1;
    check_eq("flush_rdy0", {63'd0, req_ready}, 64'd0);
    @(negedge clk);
    #1;
    check_eq("flush_rdy1", {63'd0, req_ready}, 64'd0);
    check_eq("flush_no_accept", {63'd0, mem_req_valid | resp_valid}, 64'd0);
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    cpu_req("postflush", 1'b0, 32'h10, 32'h0, rd, h, lat);
    check_eq("postflush_hit", {63'd0, h}, 64'd0);
    check_eq("postflush_mcnt", {48'd0, miss_cnt}, 64'd8);
    check_eq("postflush_hcnt", {48'd0, hit_cnt}, 64'd4);

    // Stalled miss, then reset in the middle of it
    mem_req_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h50;
    #1;
    check_eq("stall_accept_rdy", {63'd0, req_ready}, 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_mem_valid", {63'd0, mem_req_valid}, 64'd1);
      check_eq("stall_mem_addr", {32'd0, mem_addr}, 64'h50);
      @(negedge clk);
    end
    reset_n = 1'b0;
    #1;
    check_eq("midrst_mem_valid", {63'd0, mem_req_valid}, 64'd0);
    check_eq("midrst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check_eq("midrst_hcnt", {48'd0, hit_cnt}, 64'd0);
    check_eq("midrst_mcnt", {48'd0, miss_cnt}, 64'd0);
    @(negedge clk);
    reset_n       = 1'b1;
    mem_req_ready = 1'b1;
    #1;
    stale_pulse = 1'b1;
    @(negedge clk);
    #1;
    stale_pulse = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stale_no_resp", {63'd0, resp_valid}, 64'd0);
      check_eq("stale_idle", {63'd0, req_ready}, 64'd1);
    end

    // Valid bits were cleared by reset
    cpu_req("postrst", 1'b0, 32'h10, 32'h0, rd, h, lat);
    check_eq("postrst_hit", {63'd0, h}, 64'd0);
    check_eq("postrst_data", {32'd0, rd}, 64'h1234_5678);
    check_eq("postrst_mcnt", {48'd0, miss_cnt}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
